// File: rtl/seq_cla_adder_ctrl_pkg.sv
// Shared definitions for the sequenced shared-slice CLA adder:
// controller state encoding, nibble width and operand-width legality.
package seq_cla_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE = 4;

  function automatic bit width_ok(input int w);
    return (w >= 2 * NIBBLE) && ((w % NIBBLE) == 0);
  endfunction

endpackage

// File: rtl/seq_cla_adder_ctrl_cla4_slice.sv
// 4-bit carry-lookahead slice with block propagate/generate outputs,
// shared by the sequenced adder controller one nibble per cycle.
module cla4_slice
  import seq_cla_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout,
  output logic              pb,
  output logic              gb
);

  logic [NIBBLE-1:0] p;
  logic [NIBBLE-1:0] g;
  logic [NIBBLE:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is flattened from cin so no ripple path exists inside the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign pb   = &p;
  assign gb   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign c[4] = gb | (pb & cin);

  assign sum  = p ^ c[NIBBLE-1:0];
  assign cout = c[4];

endmodule

// File: rtl/seq_cla_adder_ctrl.sv
// Multi-cycle adder that time-shares one 4-bit CLA slice, LSB nibble first,
// chaining the carry through a register and accumulating word-level P/G.
module seq_cla_adder_ctrl
  import seq_cla_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg_p,
  output logic             pg_g
);

  localparam int  NSLICE      = WIDTH / NIBBLE;
  localparam int  IDX_W       = $clog2(NSLICE);
  localparam int  MSB         = WIDTH - 1;
  localparam bit  WIDTH_LEGAL = width_ok(WIDTH);

  generate
    if (!WIDTH_LEGAL) begin : g_bad_width
      $error("seq_cla_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, p_acc_q, p_acc_d, g_acc_q, g_acc_d;
  logic               cout_q, cout_d, ovf_q, ovf_d, pg_p_q, pg_p_d, pg_g_q, pg_g_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [NIBBLE-1:0]  slice_a, slice_b, slice_sum;
  logic               slice_cout, slice_pb, slice_gb;

  assign slice_a = a_q[int'(idx_q) * NIBBLE +: NIBBLE];
  assign slice_b = b_q[int'(idx_q) * NIBBLE +: NIBBLE];

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .pb   (slice_pb),
    .gb   (slice_gb)
  );

  // Result flags are computed on the last nibble so they appear with done.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    p_acc_d = p_acc_q;
    g_acc_d = g_acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    pg_p_d  = pg_p_q;
    pg_g_d  = pg_g_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          p_acc_d = 1'b1;
          g_acc_d = 1'b0;
        end
      end
      RUN: begin
        sum_d[int'(idx_q) * NIBBLE +: NIBBLE] = slice_sum;
        carry_d = slice_cout;
        p_acc_d = p_acc_q & slice_pb;
        g_acc_d = slice_gb | (slice_pb & g_acc_q);
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          state_d = DONE;
          cout_d  = slice_cout;
          pg_p_d  = p_acc_d;
          pg_g_d  = g_acc_d;
          ovf_d   = (a_q[MSB] == b_q[MSB]) & (sum_d[MSB] != a_q[MSB]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      p_acc_q <= 1'b0;
      g_acc_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pg_p_q  <= 1'b0;
      pg_g_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      p_acc_q <= p_acc_d;
      g_acc_q <= g_acc_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      pg_p_q  <= pg_p_d;
      pg_g_q  <= pg_g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign pg_p = pg_p_q;
  assign pg_g = pg_g_q;

endmodule
